// File: rtl/cdb_arbiter_pkg.sv
// tomasulo_pkg: shared result payload type and CDB arbiter constants
package tomasulo_pkg;
  typedef struct packed {
    logic [5:0]  rob_tag;
    logic [31:0] value;
    logic        exc;
  } ALU_Result_t;
  localparam int CDB_ARB_NUM_REQ      = 10;
  localparam int CDB_ARB_STARVE_LIMIT = 7;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU result handshake and CDB broadcast bundle
interface cdb_arbiter_if
  import tomasulo_pkg::*;
#(
  parameter int NUM_REQ   = CDB_ARB_NUM_REQ,
  parameter int CDB_WIDTH = 3
);
  logic [NUM_REQ-1:0]             fu_valid;
  logic [NUM_REQ-1:0]             fu_ready;
  ALU_Result_t                    fu_result [NUM_REQ];
  ALU_Result_t                    cdb_results [CDB_WIDTH];
  logic [CDB_WIDTH-1:0]           cdb_valid;
  logic [CDB_WIDTH-1:0]           cdb_rdy;
  logic [$clog2(CDB_WIDTH+1)-1:0] grant_count;
  logic [31:0]                    stall_cycles;
  modport master (
    output fu_valid, fu_result, cdb_rdy,
    input  fu_ready, cdb_results, cdb_valid, grant_count, stall_cycles
  );
  modport slave (
    input  fu_valid, fu_result, cdb_rdy,
    output fu_ready, cdb_results, cdb_valid, grant_count, stall_cycles
  );
endinterface

// File: rtl/cdb_arbiter_picker.sv
// rr_multi_picker: circular scan from ptr filling grant slots base..K-1 in order
module rr_multi_picker #(
  parameter int N = 10,
  parameter int K = 3,
  localparam int PW = $clog2(N),
  localparam int CW = $clog2(K+1)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [CW-1:0] base,
  output logic [N-1:0]  gnt [K],
  output logic [N-1:0]  mask,
  output logic [CW-1:0] cnt,
  output logic [PW-1:0] last,
  output logic          any
);
  localparam int IW = PW + 1;
  logic [IW-1:0] idx;
  always_comb begin
    gnt  = '{default: '0};
    mask = '0;
    cnt  = base;
    last = '0;
    any  = 1'b0;
    idx  = '0;
    for (int o = 0; o < N; o++) begin
      idx = {1'b0, ptr} + IW'(o);
      idx = (idx >= IW'(N)) ? idx - IW'(N) : idx;
      if (req[idx[PW-1:0]] && cnt < CW'(K)) begin
        gnt[cnt][idx[PW-1:0]] = 1'b1;
        mask[idx[PW-1:0]]     = 1'b1;
        last                  = idx[PW-1:0];
        any                   = 1'b1;
        cnt                   = cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: multi-grant CDB arbiter with round-robin, starvation override and all-or-nothing output stage
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_REQ      = CDB_ARB_NUM_REQ,
  parameter int CDB_WIDTH    = 3,
  parameter int STARVE_LIMIT = CDB_ARB_STARVE_LIMIT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  cdb_arbiter_if.slave   bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(STARVE_LIMIT+1);
  localparam int GW = $clog2(CDB_WIDTH+1);
  logic [CDB_WIDTH-1:0] cdb_valid_q, cdb_valid_d;
  ALU_Result_t          cdb_results_q [CDB_WIDTH];
  ALU_Result_t          cdb_results_d [CDB_WIDTH];
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d, last;
  logic [WW-1:0]        wait_q [NUM_REQ];
  logic [WW-1:0]        wait_d [NUM_REQ];
  logic [31:0]          stall_q, stall_d;
  logic [NUM_REQ-1:0]   starve, p1_mask, p2_mask;
  logic [NUM_REQ-1:0]   p1_gnt [CDB_WIDTH];
  logic [NUM_REQ-1:0]   p2_gnt [CDB_WIDTH];
  logic [GW-1:0]        p1_cnt, p2_cnt;
  logic [PW-1:0]        p1_last, p2_last;
  logic                 p1_any, p2_any, drain, load_en, act;
  assign drain   = (|cdb_valid_q) & (&bus.cdb_rdy);
  assign load_en = ~(|cdb_valid_q) | drain;
  assign act     = load_en & ~flush & ~rst;
  always_comb begin
    starve = '0;
    for (int i = 0; i < NUM_REQ; i++)
      starve[i] = act && bus.fu_valid[i] && wait_q[i] == WW'(STARVE_LIMIT);
  end
  rr_multi_picker #(.N(NUM_REQ), .K(CDB_WIDTH)) u_starve (
    .req(starve), .ptr(rr_ptr_q), .base(GW'(0)),
    .gnt(p1_gnt), .mask(p1_mask), .cnt(p1_cnt), .last(p1_last), .any(p1_any)
  );
  // Second pass continues filling the slots the starve pass left free
  rr_multi_picker #(.N(NUM_REQ), .K(CDB_WIDTH)) u_rr (
    .req(bus.fu_valid & ~p1_mask & {NUM_REQ{act}}), .ptr(rr_ptr_q), .base(p1_cnt),
    .gnt(p2_gnt), .mask(p2_mask), .cnt(p2_cnt), .last(p2_last), .any(p2_any)
  );
  assign bus.fu_ready     = p1_mask | p2_mask;
  assign bus.grant_count  = p2_cnt;
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_results  = cdb_results_q;
  assign bus.stall_cycles = stall_q;
  always_comb begin
    last        = p2_any ? p2_last : p1_last;
    rr_ptr_d    = flush ? '0 : (p2_cnt == '0) ? rr_ptr_q : (last == PW'(NUM_REQ-1)) ? '0 : last + PW'(1);
    stall_d     = (!load_en && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    cdb_valid_d = cdb_valid_q;
    cdb_results_d = cdb_results_q;
    for (int i = 0; i < NUM_REQ; i++)
      wait_d[i] = (flush || bus.fu_ready[i] || !bus.fu_valid[i]) ? '0 :
                  (wait_q[i] == WW'(STARVE_LIMIT)) ? wait_q[i] : wait_q[i] + WW'(1);
    for (int j = 0; j < CDB_WIDTH; j++)
      if (flush || load_en) begin
        cdb_valid_d[j]   = |(p1_gnt[j] | p2_gnt[j]);
        cdb_results_d[j] = '0;
        for (int i = 0; i < NUM_REQ; i++)
          if (p1_gnt[j][i] | p2_gnt[j][i]) cdb_results_d[j] = bus.fu_result[i];
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cdb_valid_q   <= '0;
      cdb_results_q <= '{default: '0};
      rr_ptr_q      <= '0;
      wait_q        <= '{default: '0};
      stall_q       <= '0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_results_q <= cdb_results_d;
      rr_ptr_q      <= rr_ptr_d;
      wait_q        <= wait_d;
      stall_q       <= stall_d;
    end
  always @(posedge clk)
    if (!rst) begin
      assert ($countones(bus.fu_ready) <= CDB_WIDTH);
      assert ((bus.fu_ready & ~bus.fu_valid) == '0);
      assert ((cdb_valid_q & (cdb_valid_q + CDB_WIDTH'(1))) == '0);
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  import tomasulo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int total = 0;
  int bad = 0;
  cdb_arbiter_if #(.NUM_REQ(10), .CDB_WIDTH(3)) bus ();
  cdb_arbiter #(.NUM_REQ(10), .CDB_WIDTH(3), .STARVE_LIMIT(7)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [17:0] tags();
    return {bus.cdb_results[0].rob_tag, bus.cdb_results[1].rob_tag, bus.cdb_results[2].rob_tag};
  endfunction
  initial begin
    for (int i = 0; i < 10; i++)
      bus.fu_result[i] = '{rob_tag: 6'(i), value: 32'h100 + 32'(i), exc: 1'b0};
    bus.fu_valid = '0;
    bus.cdb_rdy  = 3'b111;
    repeat (2) tick;
    chk("rst_valid", 64'(bus.cdb_valid), 64'h0);
    chk("rst_stall", 64'(bus.stall_cycles), 64'h0);
    rst = 1'b0;
    bus.fu_valid = 10'h3FF;
    #1;
    chk("t1_ready_pre", 64'(bus.fu_ready), 64'h007);
    tick;
    chk("t1_loaded", 64'(bus.cdb_valid), 64'h7);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_valid", 64'(bus.cdb_valid), 64'h0);
    chk("t1_async_ready", 64'(bus.fu_ready), 64'h0);
    chk("t1_async_gcnt", 64'(bus.grant_count), 64'h0);
    rst = 1'b0;
    #1;
    chk("t2_ready0", 64'(bus.fu_ready), 64'h007);
    chk("t2_gcnt0", 64'(bus.grant_count), 64'h3);
    tick;
    chk("t2_tags0", 64'(tags()), 64'({6'd0, 6'd1, 6'd2}));
    chk("t2_ready1", 64'(bus.fu_ready), 64'h038);
    tick;
    chk("t2_ready2", 64'(bus.fu_ready), 64'h1C0);
    tick;
    chk("t2_ready3", 64'(bus.fu_ready), 64'h203);
    tick;
    chk("t2_rr", 64'(dut.rr_ptr_q), 64'h2);
    chk("t2_tags3", 64'(tags()), 64'({6'd9, 6'd0, 6'd1}));
    bus.fu_valid = 10'h203;
    bus.cdb_rdy  = 3'b101;
    #1;
    chk("t3_ready_stall", 64'(bus.fu_ready), 64'h0);
    chk("t3_gcnt_stall", 64'(bus.grant_count), 64'h0);
    repeat (5) tick;
    chk("t3_stall_cnt", 64'(bus.stall_cycles), 64'd5);
    chk("t3_wait0", 64'(dut.wait_q[0]), 64'd5);
    chk("t3_wait9", 64'(dut.wait_q[9]), 64'd5);
    chk("t3_wait5", 64'(dut.wait_q[5]), 64'd0);
    chk("t3_hold_valid", 64'(bus.cdb_valid), 64'h7);
    chk("t3_hold_tags", 64'(tags()), 64'({6'd9, 6'd0, 6'd1}));
    chk("t3_ready_end", 64'(bus.fu_ready), 64'h0);
    bus.cdb_rdy = 3'b111;
    #1;
    chk("t3_release", 64'(bus.fu_ready), 64'h203);
    tick;
    flush = 1'b1;
    bus.fu_valid = 10'h00F;
    #1;
    chk("t6_ready", 64'(bus.fu_ready), 64'h0);
    chk("t6_gcnt", 64'(bus.grant_count), 64'h0);
    tick;
    flush = 1'b0;
    chk("t6_valid", 64'(bus.cdb_valid), 64'h0);
    chk("t6_rr", 64'(dut.rr_ptr_q), 64'h0);
    chk("t6_wait3", 64'(dut.wait_q[3]), 64'h0);
    chk("t6_slot0", 64'(bus.cdb_results[0]), 64'h0);
    bus.fu_valid = 10'h001;
    #1;
    chk("t4_ready_seed", 64'(bus.fu_ready), 64'h001);
    tick;
    bus.fu_valid = 10'h200;
    bus.cdb_rdy  = 3'b000;
    #1;
    chk("t4_ready_stall", 64'(bus.fu_ready), 64'h0);
    repeat (8) tick;
    chk("t4_wait9_sat", 64'(dut.wait_q[9]), 64'd7);
    chk("t4_stall_cnt", 64'(bus.stall_cycles), 64'd13);
    bus.fu_valid = 10'h206;
    bus.cdb_rdy  = 3'b111;
    #1;
    chk("t4_ready", 64'(bus.fu_ready), 64'h206);
    tick;
    chk("t4_tags", 64'(tags()), 64'({6'd9, 6'd1, 6'd2}));
    chk("t4_rr", 64'(dut.rr_ptr_q), 64'h3);
    bus.fu_valid = 10'h018;
    #1;
    chk("t5_pre_ready", 64'(bus.fu_ready), 64'h018);
    tick;
    chk("t5_rr5", 64'(dut.rr_ptr_q), 64'h5);
    bus.fu_valid = 10'h204;
    #1;
    chk("t5_ready", 64'(bus.fu_ready), 64'h204);
    chk("t5_gcnt", 64'(bus.grant_count), 64'h2);
    tick;
    chk("t5_valid", 64'(bus.cdb_valid), 64'h3);
    chk("t5_slot01", 64'({bus.cdb_results[0].rob_tag, bus.cdb_results[1].rob_tag}), 64'({6'd9, 6'd2}));
    chk("t5_slot2", 64'(bus.cdb_results[2]), 64'h0);
    chk("t5_rr", 64'(dut.rr_ptr_q), 64'h3);
    bus.fu_valid = '0;
    tick;
    chk("t5_empty", 64'(bus.cdb_valid), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
